// File: rtl/pulse_meas_pkg.sv
// pulse_meas_pkg: shared state encoding, default widths and result layout for pulse_meas
package pulse_meas_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 24;
   typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;
   typedef struct packed {
      logic                 ovf;
      logic [CNT_W_DEF-1:0] period;
      logic [CNT_W_DEF-1:0] width;
   } meas_res_t;
endpackage

// File: rtl/pulse_meas_hyst_cmp.sv
// pulse_hyst_cmp: registered signed hysteresis comparator with same-cycle rise/fall strobes
module pulse_hyst_cmp #(
   parameter int DATA_W = 32
) (
   input  logic                     clk_20m,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] din,
   input  logic                     din_valid,
   input  logic signed [DATA_W-1:0] th_hi,
   input  logic signed [DATA_W-1:0] th_lo,
   output logic                     lvl,
   output logic                     rise,
   output logic                     fall
);
   logic lvl_q, lvl_d;
   always_comb begin
      lvl_d = !din_valid ? lvl_q : din > th_hi ? 1'b1 : din < th_lo ? 1'b0 : lvl_q;
   end
   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) lvl_q <= 1'b0;
      else lvl_q <= lvl_d;
   end
   assign lvl  = lvl_q;
   assign rise = lvl_d & ~lvl_q;
   assign fall = ~lvl_d & lvl_q;
endmodule

// File: rtl/pulse_meas.sv
// pulse_meas: hysteresis level, saturating pulse width/period measurement, single-entry result slot
module pulse_meas
   import pulse_meas_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clk_20m,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] din,
   input  logic                     din_valid,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] th_hi,
   input  logic signed [DATA_W-1:0] th_lo,
   output logic                     lvl,
   output logic [CNT_W-1:0]         meas_width,
   output logic [CNT_W-1:0]         meas_period,
   output logic                     meas_ovf,
   output logic                     meas_valid,
   input  logic                     meas_ready,
   output logic                     lost
);
   typedef struct packed {
      logic             ovf;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] width;
   } res_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] width_q, width_d, period_q, period_d;
   logic             ovf_q, ovf_d, valid_q, valid_d, lost_q, lost_d;
   logic             rise, fall, cap, load, w_inc;
   res_t             res_q, res_d;

   pulse_hyst_cmp #(.DATA_W(DATA_W)) u_cmp (
      .clk_20m   (clk_20m),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .th_hi     (th_hi),
      .th_lo     (th_lo),
      .lvl       (lvl),
      .rise      (rise),
      .fall      (fall)
   );

   assign w_inc = state_q == HIGH && !fall;

   always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      period_d = period_q;
      ovf_d    = ovf_q;
      cap      = 1'b0;
      if (!enable) begin
         state_d  = IDLE;
         width_d  = '0;
         period_d = '0;
         ovf_d    = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = SYNC;
      end else if (rise) begin
         // every rise opens a fresh pulse; only a rise seen from LOW closes a full measurement
         cap      = state_q == LOW;
         state_d  = HIGH;
         width_d  = CNT_W'(1);
         period_d = CNT_W'(1);
         ovf_d    = 1'b0;
      end else if (din_valid && state_q != SYNC) begin
         period_d = &period_q ? period_q : period_q + CNT_W'(1);
         width_d  = w_inc && !(&width_q) ? width_q + CNT_W'(1) : width_q;
         ovf_d    = ovf_q | (&period_q) | (w_inc & (&width_q));
         state_d  = state_q == HIGH && fall ? LOW : state_q;
      end
   end

   always_comb begin
      load    = cap && (!valid_q || meas_ready);
      res_d   = load ? {ovf_q, period_q, width_q} : res_q;
      valid_d = load || (valid_q && !meas_ready);
      lost_d  = lost_q || (cap && valid_q && !meas_ready);
   end

   always_ff @(posedge clk_20m or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         width_q  <= '0;
         period_q <= '0;
         ovf_q    <= 1'b0;
         res_q    <= '0;
         valid_q  <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         width_q  <= width_d;
         period_q <= period_d;
         ovf_q    <= ovf_d;
         res_q    <= res_d;
         valid_q  <= valid_d;
         lost_q   <= lost_d;
      end
   end

   assign meas_width  = res_q.width;
   assign meas_period = res_q.period;
   assign meas_ovf    = res_q.ovf;
   assign meas_valid  = valid_q;
   assign lost        = lost_q;
endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
Downstream stage of the 8-tap pulse filter. Consumes the filtered 32-bit sample stream (the filter's pulse_out), turns it into a clean logic level with a hysteresis comparator, and measures pulse width and period in samples. Completed measurements go out through a single-entry valid/ready result register to the control/readout logic.

Parameters:
DATA_W, 32, sample width; signed two's complement; matches filter output width.
CNT_W, 24, width/period counter width; saturating.

Ports:
clk_20m  in  1  system clock, 20 MHz
rst  in  1  asynchronous reset, active-high
din  in  DATA_W  filtered sample, signed; connects to filter pulse_out
din_valid  in  1  sample strobe; tie high if the filter produces a sample every cycle
enable  in  1  measurement enable
th_hi  in  DATA_W  signed upper threshold
th_lo  in  DATA_W  signed lower threshold
lvl  out  1  registered comparator level
meas_width  out  CNT_W  high time of last complete pulse, in samples
meas_period  out  CNT_W  rising-to-rising time, in samples
meas_ovf  out  1  a counter saturated during this measurement
meas_valid  out  1  result available
meas_ready  in  1  consumer accepts the result
lost  out  1  sticky flag: a result was dropped because the slot was full

Behaviour:
- Reset (asynchronous, rst=1): lvl=0, meas_*=0, meas_valid=0, lost=0, FSM=IDLE, counters=0.
- Comparator, updated only when din_valid=1, signed compare: din > th_hi -> lvl=1; din < th_lo -> lvl=0; otherwise hold. If both conditions are true (th_lo > th_hi), set wins. Latency is 1 cycle from the sample to lvl.
- A rise is a din_valid cycle where the new lvl is 1 and the previous lvl was 0. A fall is the opposite.
- FSM states:
  - IDLE: counters held at 0. Go to SYNC when enable=1.
  - SYNC: discards any partial pulse already in progress. On a rise, go to HIGH with width=1 and period=1.
  - HIGH: on each valid sample, width++ and period++. On a fall, go to LOW and freeze width.
  - LOW: on each valid sample, period++. On a rise, capture the result, then go to HIGH with width=1 and period=1.
- From any state, enable=0 returns the FSM to IDLE on the next cycle and clears the counters. A pending result and the lost flag are kept.
- Width counts the samples with lvl=1 in the pulse. Period counts the samples from one rise up to, but not including, the next rise.
- Saturation: each counter stops at 2^CNT_W-1 and sets an internal ovf bit. The ovf bit is cleared at the start of each new pulse.
- Result capture happens on the cycle the rise is detected.
  - If meas_valid=0, or if meas_valid=1 and meas_ready=1 in the same cycle, load meas_width, meas_period and meas_ovf. meas_valid reads 1 on the following cycle.
  - Otherwise, drop the new result and set lost=1.
  - lost clears only on reset.
- Handshake: meas_valid stays high and meas_* stay stable until a cycle with meas_valid & meas_ready. meas_valid then drops next cycle, unless a capture happens in that same cycle.
- din_valid=0 freezes the comparator, counters and FSM. The handshake continues.
- Threshold changes apply to the next valid sample. No extra synchronisation is required.

Decomposition:
- Package pulse_meas_pkg:
  - FSM state enum: IDLE, SYNC, HIGH, LOW.
  - Default DATA_W and CNT_W constants.
  - Packed result typedef: {ovf, period, width}.
- Sub-module pulse_hyst_cmp: registered hysteresis comparator that outputs lvl, rise and fall.
- pulse_meas top contains the FSM, the saturating counters and the result slot.

Test Plan:
1. Steady square wave, th_hi=500, th_lo=-500; din=+1000 for 5 samples then -1000 for 3 samples, repeated -> after the second rise, meas_width=5, meas_period=8, meas_ovf=0, lost=0. Every period gives the same values.
2. Noise between thresholds; din stepping 1000, 200, -200, 300, -1000 with th ±500 -> lvl stays 1 through the ±300 samples. Exactly one fall, at the -1000 sample.
3. Backpressure: meas_ready=0 across three full periods -> the first result is held, lost=1. Then meas_ready=1 for one cycle -> meas_valid drops; the next rise loads a fresh result.
4. Saturation with CNT_W=8 and a high pulse of 300 samples -> meas_width=255, meas_ovf=1. The next normal pulse gives meas_ovf=0.
5. enable rising mid-pulse (high already 4 samples) -> the partial pulse is discarded; the first result comes only after two further rises.
6. rst asserted mid-HIGH with meas_valid=1 -> all outputs are 0 within the same cycle (asynchronous). After rst is released with enable=1, the FSM is in SYNC and no stale result appears.
